// File: rtl/borrow_lookahead_subtractor_pipe_if.sv
// Valid/ready operand and result bundle for the pipelined lookahead subtractor.
interface borrow_lookahead_subtractor_pipe_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         BIN;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  modport master (
    output in_valid, A, B, BIN, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, A, B, BIN, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/borrow_lookahead_subtractor_pipe.sv
// Pipelined A - B - BIN: operands are captured, then one G-bit group is resolved
// per stage with in-group borrow lookahead; a single enable stalls the whole pipe.
module borrow_lookahead_subtractor_pipe #(
  parameter int N = 8,
  parameter int G = 4
) (
  input  logic clk,
  input  logic rst_n,
  borrow_lookahead_subtractor_pipe_if.slave sub_if
);
  localparam int S = N / G;

  if (N % G != 0) begin : g_bad_width
    $error("borrow_lookahead_subtractor_pipe: N must be a multiple of G");
  end

  // Returns {group borrow-out, group diff}; every borrow is a flat sum of products.
  function automatic logic [G:0] grp_sub(input logic [G-1:0] a, input logic [G-1:0] b,
                                         input logic bin);
    logic [G-1:0] g;
    logic [G-1:0] p;
    logic [G:0]   brw;
    logic         term;
    g      = ~a & b;
    p      = ~(a ^ b);
    brw    = '0;
    brw[0] = bin;
    for (int j = 1; j <= G; j++) begin
      term = bin;
      for (int q = 0; q < j; q++) term = term & p[q];
      brw[j] = term;
      for (int m = 0; m < j; m++) begin
        term = g[m];
        for (int q = m + 1; q < j; q++) term = term & p[q];
        brw[j] = brw[j] | term;
      end
    end
    return {brw[G], a ^ b ^ brw[G-1:0]};
  endfunction

  logic         en;
  logic         last_vld;
  logic         cap_vld_q;
  logic         cap_bin_q;
  logic [N-1:0] cap_a_q;
  logic [N-1:0] cap_b_q;

  assign en = ~last_vld | sub_if.out_ready;

  // Capture stage: operands registered before any group is resolved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld_q <= 1'b0;
      cap_bin_q <= 1'b0;
      cap_a_q   <= '0;
      cap_b_q   <= '0;
    end else if (en) begin
      cap_vld_q <= sub_if.in_valid;
      cap_bin_q <= sub_if.BIN;
      cap_a_q   <= sub_if.A;
      cap_b_q   <= sub_if.B;
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int WI = N - G * k;
    localparam int WR = WI - G;

    logic [WI-1:0]      a_d;
    logic [WI-1:0]      b_d;
    logic               vld_d;
    logic               bin_d;
    logic               amsb_d;
    logic               bmsb_d;
    logic [G*(k+1)-1:0] diff_d;
    logic [G:0]         res;

    logic               vld_q;
    logic               brw_q;
    logic               amsb_q;
    logic               bmsb_q;
    logic [G*(k+1)-1:0] diff_q;

    assign res = grp_sub(a_d[G-1:0], b_d[G-1:0], bin_d);

    if (k == 0) begin : g_src
      assign vld_d  = cap_vld_q;
      assign a_d    = cap_a_q;
      assign b_d    = cap_b_q;
      assign bin_d  = cap_bin_q;
      assign amsb_d = cap_a_q[N-1];
      assign bmsb_d = cap_b_q[N-1];
      assign diff_d = res[G-1:0];
    end else begin : g_src
      assign vld_d  = g_stage[k-1].vld_q;
      assign a_d    = g_stage[k-1].g_rem.a_q;
      assign b_d    = g_stage[k-1].g_rem.b_q;
      assign bin_d  = g_stage[k-1].brw_q;
      assign amsb_d = g_stage[k-1].amsb_q;
      assign bmsb_d = g_stage[k-1].bmsb_q;
      assign diff_d = {res[G-1:0], g_stage[k-1].diff_q};
    end

    // Group stage k: lower diff bits, group borrow and operand MSBs advance together
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        brw_q  <= 1'b0;
        amsb_q <= 1'b0;
        bmsb_q <= 1'b0;
        diff_q <= '0;
      end else if (en) begin
        vld_q  <= vld_d;
        brw_q  <= res[G];
        amsb_q <= amsb_d;
        bmsb_q <= bmsb_d;
        diff_q <= diff_d;
      end
    end

    if (k < S - 1) begin : g_rem
      logic [WR-1:0] a_q;
      logic [WR-1:0] b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d[WI-1:G];
          b_q <= b_d[WI-1:G];
        end
      end
    end
  end

  assign last_vld         = g_stage[S-1].vld_q;
  assign sub_if.in_ready  = en;
  assign sub_if.out_valid = last_vld;
  assign sub_if.diff      = g_stage[S-1].diff_q;
  assign sub_if.bout      = g_stage[S-1].brw_q;
  assign sub_if.ovf       = (g_stage[S-1].amsb_q != g_stage[S-1].bmsb_q) &
                            (g_stage[S-1].diff_q[N-1] != g_stage[S-1].amsb_q);
endmodule

// File: tb/tb_borrow_lookahead_subtractor_pipe.sv
// Directed bench for borrow_lookahead_subtractor_pipe (N=8, G=4).
module tb_borrow_lookahead_subtractor_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  borrow_lookahead_subtractor_pipe_if #(.N(8)) bus ();

  borrow_lookahead_subtractor_pipe #(.N(8), .G(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sub_if (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    bus.BIN      = bin;
  endtask

  task automatic run_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic [7:0] ed, input logic eb, input logic eo);
    drive(1'b1, a, b, bin);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_diff"},  bus.diff, ed);
    chk({tag, "_bout"},  bus.bout, eb);
    chk({tag, "_ovf"},   bus.ovf, eo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h35, 8'h12, 1'b0);
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_diff",  bus.diff, 8'h00);
    chk("rst_bout",  bus.bout, 0);
    chk("rst_ovf",   bus.ovf, 0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);

    drive(1'b1, 8'h35, 8'h12, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("lat_t0_valid", bus.out_valid, 0);
    tick();
    chk("lat_t1_valid", bus.out_valid, 0);
    tick();
    chk("lat_t2_valid", bus.out_valid, 1);
    chk("lat_diff",     bus.diff, 8'h23);
    chk("lat_bout",     bus.bout, 0);
    chk("lat_ovf",      bus.ovf, 0);

    run_vec("v00m01",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_vec("v80m01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_vec("v7Fm FF",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_vec("v10m00b1", 8'h10, 8'h00, 1'b1, 8'h0F, 1'b0, 1'b0);
    run_vec("v00m00b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_vec("v80m00b1", 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1);
    run_vec("v5AmA5b1", 8'h5A, 8'hA5, 1'b1, 8'hB4, 1'b1, 1'b1);
    run_vec("vFFmFF",   8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);

    tick();
    drive(1'b1, 8'h05, 8'h01, 1'b0);
    tick();
    drive(1'b1, 8'h20, 8'h10, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk("bp_r1_valid", bus.out_valid, 1);
    chk("bp_r1_diff",  bus.diff, 8'h04);
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h33, 8'h03, 1'b0);
    #1;
    chk("bp_stall_ready0", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_ready", bus.in_ready, 0);
      chk("bp_stall_valid", bus.out_valid, 1);
      chk("bp_stall_diff",  bus.diff, 8'h04);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    tick();
    chk("bp_r2_valid", bus.out_valid, 1);
    chk("bp_r2_diff",  bus.diff, 8'h10);
    drive(1'b1, 8'h44, 8'h04, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    chk("bp_bubble_valid", bus.out_valid, 0);
    tick();
    chk("bp_r3_valid", bus.out_valid, 1);
    chk("bp_r3_diff",  bus.diff, 8'h30);
    tick();
    chk("bp_r4_valid", bus.out_valid, 1);
    chk("bp_r4_diff",  bus.diff, 8'h40);
    tick();
    chk("bp_drain_valid", bus.out_valid, 0);

    tick();
    drive(1'b1, 8'h35, 8'h12, 1'b0);
    tick();
    drive(1'b1, 8'h80, 8'h01, 1'b0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk("arst_pre_valid", bus.out_valid, 1);
    chk("arst_pre_diff",  bus.diff, 8'h23);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_diff",  bus.diff, 8'h00);
    chk("arst_bout",  bus.bout, 0);
    chk("arst_ovf",   bus.ovf, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("arst_idle_valid", bus.out_valid, 0);
    end
    chk("arst_idle_ready", bus.in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
